// File: rtl/sh7604_dmac_chsched_pkg.sv
// Shared types and helpers for the SH7604 DMAC channel request scheduler.
package sh7604_dmac_chsched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } DMASCHED_STATE_t;

  localparam logic [1:0] DMA_RS_DREQ = 2'b00;
  localparam logic [1:0] DMA_RS_RXI  = 2'b01;
  localparam logic [1:0] DMA_RS_TXI  = 2'b10;
  localparam logic [1:0] DMA_RS_NONE = 2'b11;

  localparam int MAX_NCH = 4;

  // Fixed priority scans from 0; round-robin scans from ptr and wraps modulo nch.
  function automatic int pickWinner(input logic [MAX_NCH-1:0] req, input int ptr,
                                    input logic rr, input int nch);
    int win;
    int idx;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_NCH; k++) begin
      idx = rr ? ((ptr + k) % nch) : k;
      if (!found && (k < nch) && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sh7604_dmac_chsched_if.sv
// Grant handshake between the channel scheduler and the DMAC transfer engine.
interface sh7604_dmac_chsched_if #(parameter int NCH = 2);
  localparam int CW = (NCH > 2) ? 2 : 1;

  logic          GNT_VALID;
  logic [CW-1:0] GNT_CH;
  logic          GNT_BURST;
  logic          XFER_BUSY;
  logic          UNIT_DONE;
  logic          LAST;

  modport master (output GNT_VALID, GNT_CH, GNT_BURST,
                  input  XFER_BUSY, UNIT_DONE, LAST);
  modport slave  (input  GNT_VALID, GNT_CH, GNT_BURST,
                  output XFER_BUSY, UNIT_DONE, LAST);
endinterface

// File: rtl/sh7604_dmac_reqdet.sv
// Per-channel request detector: DREQ edge/level sense, source select and the pending flag.
module sh7604_dmac_reqdet
  import sh7604_dmac_chsched_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R_i,
  input  logic       ELIG_i,
  input  logic       AR_i,
  input  logic       DS_i,
  input  logic       DL_i,
  input  logic [1:0] RS_i,
  input  logic       DREQ_i,
  input  logic       RXI_IRQ_i,
  input  logic       TXI_IRQ_i,
  input  logic       DONE_i,
  output logic       REQ_PEND_o
);

  logic dreqOld_q, dreqOld_d;
  logic reqPend_q, reqPend_d;
  logic rawReq, srcReq;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dreqOld_q <= 1'b0;
      reqPend_q <= 1'b0;
    end else begin
      dreqOld_q <= dreqOld_d;
      reqPend_q <= reqPend_d;
    end
  end

  // Clear beats set, so an edge arriving in the same cycle as its unit's completion is dropped.
  always_comb begin
    rawReq = (DREQ_i == DL_i) & (~DS_i | (dreqOld_q != DL_i));
    case (RS_i)
      DMA_RS_DREQ: srcReq = rawReq;
      DMA_RS_RXI:  srcReq = RXI_IRQ_i;
      DMA_RS_TXI:  srcReq = TXI_IRQ_i;
      DMA_RS_NONE: srcReq = 1'b0;
      default:     srcReq = 1'b0;
    endcase
    if (AR_i) srcReq = 1'b1;
    dreqOld_d = CE_R_i ? DREQ_i : dreqOld_q;
    reqPend_d = reqPend_q;
    if (DONE_i || !ELIG_i) reqPend_d = 1'b0;
    else if (CE_R_i && srcReq) reqPend_d = 1'b1;
  end

  assign REQ_PEND_o = reqPend_q;

endmodule

// File: rtl/sh7604_dmac_chsched.sv
// SH7604 DMAC channel scheduler: arbitrates pending channel requests and grants one at a time.
module sh7604_dmac_chsched
  import sh7604_dmac_chsched_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int RR_INIT = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE_R_i,
  input  logic             CE_F_i,
  input  logic             DME_i,
  input  logic             NMIF_i,
  input  logic             AE_i,
  input  logic             PR_i,
  input  logic [NCH-1:0]   DE_i,
  input  logic [NCH-1:0]   TE_i,
  input  logic [NCH-1:0]   AR_i,
  input  logic [NCH-1:0]   DS_i,
  input  logic [NCH-1:0]   DL_i,
  input  logic [NCH-1:0]   TB_i,
  input  logic [2*NCH-1:0] RS_i,
  input  logic [NCH-1:0]   DREQ_i,
  input  logic             RXI_IRQ_i,
  input  logic             TXI_IRQ_i,
  output logic [NCH-1:0]   REQ_PEND_o,
  sh7604_dmac_chsched_if.master bus
);

  localparam int CW = (NCH > 2) ? 2 : 1;

  DMASCHED_STATE_t state_q, state_d;
  logic [CW-1:0] gntCh_q, gntCh_d;
  logic [CW-1:0] rrPtr_q, rrPtr_d;
  logic burst_q, burst_d;

  logic [NCH-1:0] elig, reqPend, unitDone;
  logic [MAX_NCH-1:0] candReq;
  int winner;
  logic eligGnt, holdGnt, doneEvt;

  assign elig    = {NCH{DME_i & ~NMIF_i & ~AE_i}} & DE_i & ~TE_i;
  assign doneEvt = CE_F_i & bus.UNIT_DONE & (state_q == XFER);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign unitDone[i] = doneEvt & (gntCh_q == CW'(i));
    sh7604_dmac_reqdet u_reqdet (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .CE_R_i     (CE_R_i),
      .ELIG_i     (elig[i]),
      .AR_i       (AR_i[i]),
      .DS_i       (DS_i[i]),
      .DL_i       (DL_i[i]),
      .RS_i       (RS_i[2*i +: 2]),
      .DREQ_i     (DREQ_i[i]),
      .RXI_IRQ_i  (RXI_IRQ_i),
      .TXI_IRQ_i  (TXI_IRQ_i),
      .DONE_i     (unitDone[i]),
      .REQ_PEND_o (reqPend[i])
    );
  end

  assign REQ_PEND_o = reqPend;

  always_comb begin
    candReq          = '0;
    candReq[NCH-1:0] = reqPend & elig;
  end

  assign winner  = pickWinner(candReq, int'(rrPtr_q), PR_i, NCH);
  assign eligGnt = elig[gntCh_q];
  assign holdGnt = AR_i[gntCh_q] | (DREQ_i[gntCh_q] == DL_i[gntCh_q]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gntCh_q <= '0;
      burst_q <= 1'b0;
      rrPtr_q <= CW'(RR_INIT);
    end else begin
      state_q <= state_d;
      gntCh_q <= gntCh_d;
      burst_q <= burst_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  // A granted unit is never cut short: loss of eligibility in XFER waits for UNIT_DONE.
  always_comb begin
    state_d = state_q;
    gntCh_d = gntCh_q;
    burst_d = burst_q;
    rrPtr_d = rrPtr_q;
    if (CE_F_i) begin
      case (state_q)
        IDLE: begin
          if (|candReq) begin
            state_d = GRANT;
            gntCh_d = CW'(winner);
            burst_d = TB_i[gntCh_d] | AR_i[gntCh_d];
          end
        end
        GRANT: begin
          if (!eligGnt) state_d = RELEASE;
          else if (bus.XFER_BUSY) state_d = XFER;
        end
        XFER: begin
          if (bus.UNIT_DONE && (bus.LAST || !eligGnt || !(burst_q && holdGnt)))
            state_d = RELEASE;
        end
        RELEASE: begin
          state_d = IDLE;
          if (PR_i) rrPtr_d = (gntCh_q == CW'(NCH-1)) ? '0 : gntCh_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    logic gntValid;
    gntValid      = (state_q == GRANT) || (state_q == XFER);
    bus.GNT_VALID = gntValid;
    bus.GNT_CH    = gntCh_q;
    bus.GNT_BURST = burst_q & gntValid;
  end

endmodule
